// File: rtl/dmem_access_unit.sv
// dmem_access_unit: single-outstanding scalar/vector load/store initiator for the dual-width dmem port.
// Build option: define DMEM_OUTREG_EN when dmem has registered outputs (two-cycle read latency).
module dmem_access_unit #(
   parameter int unsigned SCALAR_AW = 18,
   parameter int unsigned VECTOR_AW = 14
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_we,
   input  logic         req_vec,
   input  logic [31:0]  req_addr,
   input  logic [15:0]  req_wdata_s,
   input  logic [255:0] req_wdata_v,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [15:0]  rsp_rdata_s,
   output logic [255:0] rsp_rdata_v,
   output logic         rsp_err,
   output logic         mem_w_enable,
   output logic         mem_src_sel,
   output logic [31:0]  mem_addr,
   output logic [15:0]  mem_w_data_a,
   output logic [255:0] mem_w_data_b,
   input  logic [15:0]  mem_q_a,
   input  logic [255:0] mem_q_b
);

`ifdef DMEM_OUTREG_EN
   localparam int unsigned RD_LAT = 2;
`else
   localparam int unsigned RD_LAT = 1;
`endif
   localparam int unsigned AW    = 32;
   localparam int unsigned SW    = 16;
   localparam int unsigned VW    = 256;
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_wait_cnt;
   logic [CNT_W-1:0]   w_wait_cnt;
   logic               r_we;
   logic               w_we;
   logic               r_req_ready;
   logic               w_req_ready;
   logic               r_rsp_valid;
   logic               w_rsp_valid;
   logic               r_rsp_err;
   logic               w_rsp_err;
   logic [SW-1:0]      r_rsp_rdata_s;
   logic [SW-1:0]      w_rsp_rdata_s;
   logic [VW-1:0]      r_rsp_rdata_v;
   logic [VW-1:0]      w_rsp_rdata_v;
   logic               r_mem_we;
   logic               w_mem_we;
   logic               r_mem_sel;
   logic               w_mem_sel;
   logic [AW-1:0]      r_mem_addr;
   logic [AW-1:0]      w_mem_addr;
   logic [SW-1:0]      r_mem_wd_a;
   logic [SW-1:0]      w_mem_wd_a;
   logic [VW-1:0]      r_mem_wd_b;
   logic [VW-1:0]      w_mem_wd_b;
   logic               w_in_range;

   // Upper address bits beyond the addressed space must be clear.
   always_comb begin
      if (req_vec) begin
         w_in_range = (req_addr[AW-1:VECTOR_AW] == '0);
      end else begin
         w_in_range = (req_addr[AW-1:SCALAR_AW] == '0);
      end
   end

   // State register plus all registered outputs and captured request fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_wait_cnt    <= '0;
         r_we          <= 1'b0;
         r_req_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_err     <= 1'b0;
         r_rsp_rdata_s <= '0;
         r_rsp_rdata_v <= '0;
         r_mem_we      <= 1'b0;
         r_mem_sel     <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wd_a    <= '0;
         r_mem_wd_b    <= '0;
      end else begin
         r_state       <= w_next;
         r_wait_cnt    <= w_wait_cnt;
         r_we          <= w_we;
         r_req_ready   <= w_req_ready;
         r_rsp_valid   <= w_rsp_valid;
         r_rsp_err     <= w_rsp_err;
         r_rsp_rdata_s <= w_rsp_rdata_s;
         r_rsp_rdata_v <= w_rsp_rdata_v;
         r_mem_we      <= w_mem_we;
         r_mem_sel     <= w_mem_sel;
         r_mem_addr    <= w_mem_addr;
         r_mem_wd_a    <= w_mem_wd_a;
         r_mem_wd_b    <= w_mem_wd_b;
      end
   end

   // Next-state and next-output logic; mem_* fields hold unless a new in-range request is taken.
   always_comb begin
      w_next        = r_state;
      w_wait_cnt    = r_wait_cnt;
      w_we          = r_we;
      w_rsp_err     = r_rsp_err;
      w_rsp_rdata_s = r_rsp_rdata_s;
      w_rsp_rdata_v = r_rsp_rdata_v;
      w_mem_we      = 1'b0;
      w_mem_sel     = r_mem_sel;
      w_mem_addr    = r_mem_addr;
      w_mem_wd_a    = r_mem_wd_a;
      w_mem_wd_b    = r_mem_wd_b;

      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_we          = req_we;
               w_rsp_err     = ~w_in_range;
               w_rsp_rdata_s = '0;
               w_rsp_rdata_v = '0;
               if (w_in_range) begin
                  w_next     = S_ISSUE;
                  w_mem_we   = req_we;
                  w_mem_sel  = req_vec;
                  w_mem_addr = req_addr;
                  w_mem_wd_a = req_wdata_s;
                  w_mem_wd_b = req_wdata_v;
               end else begin
                  w_next = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            if (r_we) begin
               w_next = S_RESP;
            end else begin
               w_next     = S_WAIT;
               w_wait_cnt = CNT_W'(RD_LAT - 1);
            end
         end
         S_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_next        = S_RESP;
               w_rsp_rdata_s = mem_q_a;
               w_rsp_rdata_v = mem_q_b;
            end else begin
               w_wait_cnt = r_wait_cnt - CNT_W'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase

      w_req_ready = (w_next == S_IDLE);
      w_rsp_valid = (w_next == S_RESP);
   end

   assign req_ready    = r_req_ready;
   assign rsp_valid    = r_rsp_valid;
   assign rsp_err      = r_rsp_err;
   assign rsp_rdata_s  = r_rsp_rdata_s;
   assign rsp_rdata_v  = r_rsp_rdata_v;
   assign mem_w_enable = r_mem_we;
   assign mem_src_sel  = r_mem_sel;
   assign mem_addr     = r_mem_addr;
   assign mem_w_data_a = r_mem_wd_a;
   assign mem_w_data_b = r_mem_wd_b;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and random checks of dmem_access_unit against a transaction-level model.
// Uses DMEM_OUTREG_EN the same way as the design to select the memory read latency.
module tb_dmem_access_unit;

`ifdef DMEM_OUTREG_EN
   localparam int RD_LAT = 2;
`else
   localparam int RD_LAT = 1;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_we = 1'b0;
   logic         req_vec = 1'b0;
   logic [31:0]  req_addr = '0;
   logic [15:0]  req_wdata_s = '0;
   logic [255:0] req_wdata_v = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [15:0]  rsp_rdata_s;
   logic [255:0] rsp_rdata_v;
   logic         rsp_err;
   logic         mem_w_enable;
   logic         mem_src_sel;
   logic [31:0]  mem_addr;
   logic [15:0]  mem_w_data_a;
   logic [255:0] mem_w_data_b;
   logic [15:0]  mem_q_a;
   logic [255:0] mem_q_b;

   dmem_access_unit dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_vec(req_vec),
      .req_addr(req_addr), .req_wdata_s(req_wdata_s), .req_wdata_v(req_wdata_v),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata_s(rsp_rdata_s),
      .rsp_rdata_v(rsp_rdata_v), .rsp_err(rsp_err),
      .mem_w_enable(mem_w_enable), .mem_src_sel(mem_src_sel), .mem_addr(mem_addr),
      .mem_w_data_a(mem_w_data_a), .mem_w_data_b(mem_w_data_b),
      .mem_q_a(mem_q_a), .mem_q_b(mem_q_b)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk = n_chk + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- memory contents: DUT-side RAM and reference copy ----------------
   logic [15:0] ram  [int];
   logic [15:0] refm [int];

   function automatic logic [15:0] dflt(input int i);
      return 16'(i * 40503 + 7);
   endfunction
   function automatic logic [15:0] ram_rd(input int i);
      return ram.exists(i) ? ram[i] : dflt(i);
   endfunction
   function automatic logic [15:0] ref_rd(input int i);
      return refm.exists(i) ? refm[i] : dflt(i);
   endfunction
   function automatic logic [255:0] ram_line(input int l);
      logic [255:0] v;
      for (int i = 0; i < 16; i++) v[16*i +: 16] = ram_rd(l * 16 + i);
      return v;
   endfunction
   function automatic logic [255:0] ref_line(input int l);
      logic [255:0] v;
      for (int i = 0; i < 16; i++) v[16*i +: 16] = ref_rd(l * 16 + i);
      return v;
   endfunction

   // Synchronous dual-width RAM, optionally with an output register stage.
   logic [15:0]  q1_a, q2_a;
   logic [255:0] q1_b, q2_b;
   always @(posedge clk) begin
      int sa;
      int la;
      sa = int'(mem_addr[17:0]);
      la = int'(mem_addr[13:0]);
      q1_a <= ram_rd(sa);
      q1_b <= ram_line(la);
      q2_a <= q1_a;
      q2_b <= q1_b;
      if (mem_w_enable) begin
         if (mem_src_sel) begin
            for (int i = 0; i < 16; i++) ram[la * 16 + i] = mem_w_data_b[16*i +: 16];
         end else begin
            ram[sa] = mem_w_data_a;
         end
      end
   end
   assign mem_q_a = (RD_LAT == 2) ? q2_a : q1_a;
   assign mem_q_b = (RD_LAT == 2) ? q2_b : q1_b;

   // ---------------- transaction-level reference model ----------------
   typedef enum int {M_IDLE, M_BUSY, M_RESP} mph_t;
   mph_t         m_ph = M_IDLE;
   int           m_cnt = 0;
   bit           m_issue = 1'b0;
   logic         e_we, e_vec, e_err;
   logic [31:0]  e_addr;
   logic [15:0]  e_ws, e_rs;
   logic [255:0] e_wv, e_rv;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph    = M_IDLE;
         m_issue = 1'b0;
      end else begin
         case (m_ph)
            M_IDLE: if (req_valid) begin
               e_we   = req_we;
               e_vec  = req_vec;
               e_addr = req_addr;
               e_ws   = req_wdata_s;
               e_wv   = req_wdata_v;
               e_err  = req_vec ? ((req_addr >> 14) != 0) : ((req_addr >> 18) != 0);
               e_rs   = '0;
               e_rv   = '0;
               if (e_err) begin
                  m_ph = M_RESP;
               end else begin
                  m_ph    = M_BUSY;
                  m_issue = 1'b1;
                  m_cnt   = req_we ? 1 : 1 + RD_LAT;
                  if (!req_we) begin
                     e_rs = ref_rd(int'(req_addr[17:0]));
                     e_rv = ref_line(int'(req_addr[13:0]));
                  end
               end
            end
            M_BUSY: begin
               if (m_issue && e_we) begin
                  if (e_vec) begin
                     for (int i = 0; i < 16; i++)
                        refm[int'(e_addr[13:0]) * 16 + i] = e_wv[16*i +: 16];
                  end else begin
                     refm[int'(e_addr[17:0])] = e_ws;
                  end
               end
               m_issue = 1'b0;
               m_cnt   = m_cnt - 1;
               if (m_cnt == 0) m_ph = M_RESP;
            end
            default: if (rsp_ready) m_ph = M_IDLE;
         endcase
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", 256'(req_ready), 256'(1'b1));
         chk("rst_rsp_valid", 256'(rsp_valid), 256'(1'b0));
         chk("rst_mem_w_enable", 256'(mem_w_enable), 256'(1'b0));
         chk("rst_rsp_err", 256'(rsp_err), 256'(1'b0));
         chk("rst_mem_addr", 256'(mem_addr), 256'(32'h0));
      end else begin
         chk("req_ready", 256'(req_ready), 256'(m_ph == M_IDLE));
         chk("rsp_valid", 256'(rsp_valid), 256'(m_ph == M_RESP));
         chk("mem_w_enable", 256'(mem_w_enable), 256'(m_ph == M_BUSY && m_issue && e_we));
         if (m_ph == M_BUSY && m_issue) begin
            chk("mem_addr", 256'(mem_addr), 256'(e_addr));
            chk("mem_src_sel", 256'(mem_src_sel), 256'(e_vec));
            if (e_we) begin
               chk("mem_w_data_a", 256'(mem_w_data_a), 256'(e_ws));
               chk("mem_w_data_b", mem_w_data_b, e_wv);
            end
         end
         if (m_ph == M_RESP) begin
            chk("rsp_err", 256'(rsp_err), 256'(e_err));
            chk("rsp_rdata_s", 256'(rsp_rdata_s), 256'(e_rs));
            chk("rsp_rdata_v", rsp_rdata_v, e_rv);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic we, input logic vec, input logic [31:0] a,
                       input logic [15:0] ws, input logic [255:0] wv, output int acc);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_vec = vec; req_addr = a;
      req_wdata_s = ws; req_wdata_v = wv;
      n = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n = n + 1;
      end
      if (!req_ready) begin
         n_chk = n_chk + 1;
         $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
      end
      acc = cyc;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat, output int wec, output logic sel,
                           output logic [31:0] addr, output logic err,
                           output logic [15:0] rs, output logic [255:0] rv);
      lat = 0; wec = 0; sel = 1'b0; addr = '0; err = 1'b0; rs = '0; rv = '0;
      while (lat < 40) begin
         @(negedge clk);
         lat = lat + 1;
         if (mem_w_enable) begin
            wec  = wec + 1;
            sel  = mem_src_sel;
            addr = mem_addr;
         end
         if (rsp_valid) begin
            err = rsp_err; rs = rsp_rdata_s; rv = rsp_rdata_v;
            return;
         end
      end
      n_chk = n_chk + 1;
      $display("FAIL rsp_timeout: no rsp_valid within %0d cycles, required a response", lat);
   endtask

   int           acc, lat, wec;
   int           acc_t [8];
   logic         sel, err;
   logic [31:0]  addr;
   logic [15:0]  rs;
   logic [255:0] rv, pat, held_v;

   initial begin
      pat = {16{16'hA5A5}};

      // Reset values.
      repeat (2) @(negedge clk);
      chk("init_req_ready", 256'(req_ready), 256'(1'b1));
      chk("init_mem_w_data_b", mem_w_data_b, 256'(0));
      chk("init_rsp_rdata_v", rsp_rdata_v, 256'(0));
      rst_n = 1'b1;
      rsp_ready = 1'b1;

      // Scalar store then load at the top of scalar space.
      send(1'b1, 1'b0, 32'h0003FFFF, 16'hBEEF, '0, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      chk("s_st_lat", 256'(lat), 256'(2));
      chk("s_st_we_cycles", 256'(wec), 256'(1));
      chk("s_st_sel", 256'(sel), 256'(1'b0));
      chk("s_st_addr", 256'(addr), 256'(32'h0003FFFF));
      send(1'b0, 1'b0, 32'h0003FFFF, 16'h0, '0, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      chk("s_ld_lat", 256'(lat), 256'(2 + RD_LAT));
      chk("s_ld_data", 256'(rs), 256'(16'hBEEF));
      chk("s_ld_err", 256'(err), 256'(1'b0));

      // Vector store then load at the top of vector space.
      send(1'b1, 1'b1, 32'h00003FFF, 16'h0, pat, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      chk("v_st_sel", 256'(sel), 256'(1'b1));
      chk("v_st_we_cycles", 256'(wec), 256'(1));
      send(1'b0, 1'b1, 32'h00003FFF, 16'h0, '0, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      chk("v_ld_data", rv, pat);
      chk("v_ld_lat", 256'(lat), 256'(2 + RD_LAT));

      // Out-of-range requests, just past each space.
      send(1'b1, 1'b0, 32'h00040000, 16'h1111, '0, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      chk("oor_s_lat", 256'(lat), 256'(1));
      chk("oor_s_err", 256'(err), 256'(1'b1));
      chk("oor_s_we_cycles", 256'(wec), 256'(0));
      send(1'b1, 1'b1, 32'h00004000, 16'h0, pat, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      chk("oor_v_lat", 256'(lat), 256'(1));
      chk("oor_v_err", 256'(err), 256'(1'b1));
      chk("oor_v_we_cycles", 256'(wec), 256'(0));
      chk("oor_v_rdata", rv, 256'(0));

      // Response backpressure with a competing request offered.
      @(negedge clk);
      rsp_ready = 1'b0;
      send(1'b0, 1'b1, 32'h00003FFF, 16'h0, '0, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      held_v = rv;
      chk("bp_first_data", held_v, pat);
      req_valid = 1'b1; req_we = 1'b1; req_vec = 1'b0; req_addr = 32'h10; req_wdata_s = 16'h7777;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 256'(rsp_valid), 256'(1'b1));
         chk("bp_req_ready", 256'(req_ready), 256'(1'b0));
         chk("bp_rdata_v", rsp_rdata_v, held_v);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 256'(req_ready), 256'(1'b1));
      chk("bp_release_valid", 256'(rsp_valid), 256'(1'b0));
      chk("bp_no_write", 256'(mem_w_enable), 256'(1'b0));

      // Reset during the issue cycle of a store.
      send(1'b1, 1'b0, 32'h00000005, 16'h1234, '0, acc);
      chk("rst_issue_we", 256'(mem_w_enable), 256'(1'b1));
      rst_n = 1'b0;
      #1;
      chk("rst_drop_we", 256'(mem_w_enable), 256'(1'b0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_rsp", 256'(rsp_valid), 256'(1'b0));
         chk("rst_ready_after", 256'(req_ready), 256'(1'b1));
      end
      send(1'b0, 1'b0, 32'h00000005, 16'h0, '0, acc);
      wait_rsp(lat, wec, sel, addr, err, rs, rv);
      chk("rst_dropped_store", 256'(rs), 256'(dflt(5)));

      // Throughput: eight back-to-back loads.
      for (int i = 0; i < 8; i++) begin
         send(1'b0, 1'b0, 32'($urandom_range(0, 32'h3FFFF)), 16'h0, '0, acc);
         acc_t[i] = acc;
      end
      for (int i = 1; i < 8; i++) chk("tput_interval", 256'(acc_t[i] - acc_t[i-1]), 256'(3 + RD_LAT));
      repeat (8) @(negedge clk);

      // Random traffic checked cycle by cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         int r;
         logic [255:0] w;
         @(negedge clk);
         r = $urandom_range(0, 9);
         req_vec = 1'($urandom_range(0, 1));
         req_we  = 1'($urandom_range(0, 1));
         if (r < 6) req_addr = req_vec ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 63));
         else if (r == 6) req_addr = req_vec ? 32'h3FFF : 32'h3FFFF;
         else req_addr = $urandom;
         req_wdata_s = 16'($urandom);
         for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
         req_wdata_v = w;
         req_valid = ($urandom_range(0, 2) != 0);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (10) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
